uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, the synthesisable successor to the fixed 8N1 bit-shift stimulus used at system level. It accepts words over a valid/ready handshake and buffers them in a FIFO. Each word is serialised onto a single TXD line with configurable data width, parity and stop bits, at a baud rate set by a clock divider. It sits between a bus-side register block and the board TXD pin, and also serves as a reusable UART driver in system testbenches.

## Interface
- CLK_DIV, 1250: clk cycles per UART bit; legal range ≥2.
- DATA_BITS, 8: data bits per frame; legal range 5–8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two, ≥2.

- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  DATA_BITS  word to transmit.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  FIFO can accept a word; equals !full.
- o_txd  output  1  serial line, idle high, registered.
- o_busy  output  1  a frame is on the line (FSM not IDLE).
- o_fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently queued.

## Operation
- Write: a word is written into the FIFO on any clk edge where i_valid && o_ready. With i_valid high and the FIFO full, nothing is written and the word is not lost; the sender holds it.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: o_txd=1. If the FIFO is non-empty, pop the head word into the shift register, load bit counter 0 and divider 0, drive o_txd=0, and go to START.
  - START: hold for CLK_DIV cycles, then go to DATA with o_txd=shift[0].
  - DATA: data goes LSB first. Each bit lasts CLK_DIV cycles. After DATA_BITS bits, go to PAR if PARITY≠0, else STOP.
  - PAR: o_txd = XOR of the data bits for even parity, inverted for odd parity. The bit lasts CLK_DIV cycles, then go to STOP.
  - STOP: o_txd=1 for STOP_BITS×CLK_DIV cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go directly to START (o_txd=0 on that edge, no idle gap);
    - otherwise go to IDLE.
- Parity is computed from the popped word and latched at pop time.
- Bits of i_data above DATA_BITS do not exist; the width is exactly DATA_BITS.
- Divider: 0..CLK_DIV-1 counter. It restarts at 0 at every bit boundary and is not free-running.
- FIFO:
  - Simultaneous write and pop in the same cycle leaves o_fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full when count==FIFO_DEPTH; empty when count==0.
- Reset, including mid-frame: the FIFO is flushed and the FSM goes to IDLE. Reset values are o_txd=1, o_busy=0, o_ready=1, o_fifo_count=0, and all counters 0. A partially sent frame is abandoned and the line returns high immediately.

## Timing
- Word accepted at edge N: o_fifo_count increments after edge N. If the FSM is IDLE, the pop happens and o_txd falls at edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles, exact to the cycle.
- o_busy rises on the same edge o_txd falls for the start bit. It falls on the edge the FSM enters IDLE.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle. There is no extra idle cycle.
- o_ready is combinational from the registered count, so it reflects the count after the previous edge.

## Test plan
- Defaults (8N1, CLK_DIV=1250), write 0x61 -> o_txd holds each level for 1250 cycles and the sequence is 0,1,0,0,0,0,1,1,0,1. Total 12500 cycles; o_busy high throughout.
- CLK_DIV=4, PARITY=2, STOP_BITS=2, write 0x61 -> the sequence is 0,1,0,0,0,0,1,1,0,1(par),1,1. Frame is 48 cycles. With PARITY=1 the parity bit is 0.
- CLK_DIV=4, DATA_BITS=5, write 0x15 -> the sequence is 0,1,0,1,0,1,1. Frame is 28 cycles.
- FIFO_DEPTH=4, i_valid held high with words 0x01–0x06 -> o_ready drops once count hits 4. No word is dropped. All six frames are sent back-to-back with no idle cycles between stop and start. o_fifo_count returns to 0.
- Simultaneous push and pop at count 2 -> count stays 2. Pointer wrap is exercised by sending 2×FIFO_DEPTH words; received data matches in order.
- Assert rst for one cycle during the 3rd data bit -> o_txd=1 and o_busy=0 immediately, the count becomes 0, and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO. Words enter over a
// valid/ready handshake and leave as start/data/parity/stop frames on o_txd.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 1250,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_BITS-1:0]                 i_data,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic                                 o_txd,
  output logic                                 o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic [3:0]           bit_cnt_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic                 txd_r;
  logic                 busy_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 div_end_s;
  logic                 stop_end_s;
  logic [DATA_BITS-1:0] head_s;

  assign full_s     = (count_r == CNT_FULL);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign push_s     = i_valid && !full_s;
  assign div_end_s  = (div_cnt_r == DIV_LAST);
  assign stop_end_s = (state_r == STOP) && div_end_s && (bit_cnt_r == STOP_LAST);
  // The FIFO is popped either from idle or straight out of the last stop cycle.
  assign pop_s      = !empty_s && ((state_r == IDLE) || stop_end_s);
  assign head_s     = mem_r[rd_ptr_r];

  assign o_ready      = !full_s;
  assign o_txd        = txd_r;
  assign o_busy       = busy_r;
  assign o_fifo_count = count_r;

  // FIFO storage; flushing is done through the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer: divider, bit counter, shift register and line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_BITS{1'b0}};
      par_r     <= 1'b0;
      bit_cnt_r <= 4'd0;
      div_cnt_r <= {DIV_W{1'b0}};
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r   <= head_s;
            par_r     <= parity_of(head_s);
            bit_cnt_r <= 4'd0;
            div_cnt_r <= {DIV_W{1'b0}};
            txd_r     <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= START;
          end else begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        START: begin
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= 4'd0;
            txd_r     <= shift_r[0];
            state_r   <= DATA;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        DATA: begin
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= 4'd0;
              if (PARITY != 0) begin
                txd_r   <= par_r;
                state_r <= PAR;
              end else begin
                txd_r   <= 1'b1;
                state_r <= STOP;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              txd_r     <= shift_r[1];
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        PAR: begin
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= 4'd0;
            txd_r     <= 1'b1;
            state_r   <= STOP;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        STOP: begin
          if (div_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            if (bit_cnt_r == STOP_LAST) begin
              bit_cnt_r <= 4'd0;
              // Next word goes out with no idle gap when one is waiting.
              if (pop_s) begin
                shift_r <= head_s;
                par_r   <= parity_of(head_s);
                txd_r   <= 1'b0;
                busy_r  <= 1'b1;
                state_r <= START;
              end else begin
                txd_r   <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
          div_cnt_r <= {DIV_W{1'b0}};
          txd_r     <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-and-frame-time model predicts
// every output each cycle; a few literal frame captures pin that model down.
module tb_uart_tx_fifo;

  localparam int CD    = 4;
  localparam int DB    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       valid;
  logic       ready, txd, busy;
  logic [2:0] count;

  logic [4:0] din_b;
  logic       valid_b;
  logic       ready_b, txd_b, busy_b;
  logic [2:0] count_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB),
                 .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .i_data(din), .i_valid(valid), .o_ready(ready),
    .o_txd(txd), .o_busy(busy), .o_fifo_count(count));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .i_data(din_b), .i_valid(valid_b), .o_ready(ready_b),
    .o_txd(txd_b), .o_busy(busy_b), .o_fifo_count(count_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: a queue of accepted words plus the time into the current frame.
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         t = 0;
  logic [7:0] word = 8'h00;
  bit         m_wr = 1'b0;

  function automatic logic frame_bit(input logic [7:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
    if (PAR != 0 && idx == DB + 1) return (PAR == 2) ? (^w) : ~(^w);
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int sz;
    if (rst) begin
      q.delete();
      active = 1'b0;
      t      = 0;
      m_wr   = 1'b0;
    end else begin
      sz   = q.size();
      m_wr = valid && (sz < DEPTH);
      if (active) begin
        t++;
        if (t == FRAME) begin
          if (sz > 0) begin
            word = q.pop_front();
            t    = 0;
          end else begin
            active = 1'b0;
          end
        end
      end else if (sz > 0) begin
        word   = q.pop_front();
        active = 1'b1;
        t      = 0;
      end
      if (m_wr) q.push_back(din);
    end
  end

  bit seen_full = 1'b0;

  always @(negedge clk) begin
    check("txd",   txd,   active ? frame_bit(word, t / CD) : 1'b1);
    check("busy",  busy,  active);
    check("count", count, q.size());
    check("ready", ready, q.size() < DEPTH);
    if (count == 3'd4) seen_full = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] d);
    bit ok = 1'b0;
    din   = d;
    valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (m_wr) begin
        ok = 1'b1;
        break;
      end
    end
    valid = 1'b0;
    if (!ok) fail_now("push_timeout");
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (!active && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic capture(input bit sel, input int cd, input int nbits,
                         output int n, output logic [15:0] v, output bit stable);
    logic rec [256];
    n = 0;
    v = 16'h0000;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? busy_b : busy) break;
    end
    while ((sel ? busy_b : busy) && n < 256) begin
      rec[n] = sel ? txd_b : txd;
      n++;
      @(negedge clk);
    end
    for (int k = 0; k < nbits; k++) begin
      v[k] = rec[k*cd];
      for (int j = 1; j < cd; j++) begin
        if (rec[k*cd+j] !== rec[k*cd]) stable = 1'b0;
      end
    end
  endtask

  initial begin
    int          n;
    logic [15:0] v;
    bit          stable;
    bit          ok;
    bit          busy_seen;

    rst = 1'b1; valid = 1'b0; din = 8'h00; valid_b = 1'b0; din_b = 5'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_count", count, 3'd0);
    check("rst_b_ready", ready_b, 1'b1);
    rst = 1'b0;
    tick();

    // 0x61 with even parity and two stop bits.
    push_word(8'h61);
    capture(1'b0, CD, 12, n, v, stable);
    check("a_frame_len", n, 48);
    check("a_sequence", v, 16'h0EC2);
    check("a_bit_stable", stable, 1'b1);
    wait_idle(20);

    // 5-bit, no parity, one stop bit: 0x15.
    din_b = 5'h15;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    capture(1'b1, 4, 7, n, v, stable);
    check("b_frame_len", n, 28);
    check("b_sequence", v, 16'h006A);
    check("b_bit_stable", stable, 1'b1);
    check("b_count_end", count_b, 3'd0);

    // Burst of six words with valid held high.
    for (int w = 1; w <= 6; w++) push_word(8'(w));
    wait_idle(400);
    check("burst_full_seen", seen_full, 1'b1);
    check("burst_count_end", count, 3'd0);

    // Push on the same edge as a pop with two words queued.
    for (int w = 0; w < 3; w++) push_word(8'hA0 + 8'(w));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (active && t == FRAME - 1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("simul_wait");
    din = 8'h5A;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("simul_count", count, 3'd2);
    wait_idle(400);

    // Two full trips round the pointers.
    for (int w = 0; w < 2 * DEPTH; w++) push_word(8'($urandom));
    wait_idle(800);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      din   = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    wait_idle(600);

    // Reset during the third data bit with more words queued.
    for (int w = 0; w < 3; w++) push_word(8'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (active && t == 3 * CD + 1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("reset_wait");
    #2;
    rst = 1'b1;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 3'd0);
    tick();
    rst = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy) busy_seen = 1'b1;
    end
    check("no_frame_after_rst", busy_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
